// File: rtl/key_debounce_pkg.sv
// Shared types and constants for the key debouncer.
// Optional feature macro used by this slice: KEY_EDGE_PULSE_EN.
package key_debounce_pkg;

   typedef enum logic [1:0] {
      S_LOW     = 2'd0,
      S_WAIT_HI = 2'd1,
      S_HIGH    = 2'd2,
      S_WAIT_LO = 2'd3
   } key_state_e;

   // 20 ms at 50 MHz; the short value keeps simulation runs quick
   localparam int DEBOUNCE_CYCLES_DEFAULT = 1_000_000;
   localparam int DEBOUNCE_CYCLES_SIM     = 8;

endpackage

// File: rtl/key_debounce_chan.sv
// One key channel: 2-flop synchroniser, debounce FSM with hold counter,
// and registered edge pulses when KEY_EDGE_PULSE_EN is defined.
module key_debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_raw,
   output logic key_out
`ifdef KEY_EDGE_PULSE_EN
   ,
   output logic key_rise,
   output logic key_fall
`endif
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             sync1_r;
   logic             ks_r;
   key_state_e       state_r;
   key_state_e       state_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_s;
   logic             out_s;
   logic             key_out_r;

   // State register: synchroniser, FSM state, hold counter and debounced level
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_r   <= 1'b0;
         ks_r      <= 1'b0;
         state_r   <= S_LOW;
         cnt_r     <= CNT_ZERO;
         key_out_r <= 1'b0;
      end else begin
         sync1_r   <= key_raw;
         ks_r      <= sync1_r;
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         key_out_r <= out_s;
      end
   end

   // Next-state logic; any bounce in a wait state restarts the window from zero
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      case (state_r)
         S_LOW: begin
            cnt_s = CNT_ZERO;
            if (ks_r) begin
               state_s = S_WAIT_HI;
            end else begin
               state_s = S_LOW;
            end
         end
         S_WAIT_HI: begin
            if (!ks_r) begin
               state_s = S_LOW;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_s = S_HIGH;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = S_WAIT_HI;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         S_HIGH: begin
            cnt_s = CNT_ZERO;
            if (!ks_r) begin
               state_s = S_WAIT_LO;
            end else begin
               state_s = S_HIGH;
            end
         end
         S_WAIT_LO: begin
            if (ks_r) begin
               state_s = S_HIGH;
               cnt_s   = CNT_ZERO;
            end else if (cnt_r == CNT_LAST) begin
               state_s = S_LOW;
               cnt_s   = CNT_ZERO;
            end else begin
               state_s = S_WAIT_LO;
               cnt_s   = cnt_r + CNT_ONE;
            end
         end
         default: begin
            state_s = S_LOW;
            cnt_s   = CNT_ZERO;
         end
      endcase
   end

   // Output logic: the level registered alongside the state it belongs to
   always_comb begin
      out_s = 1'b0;
      case (state_s)
         S_LOW:     out_s = 1'b0;
         S_WAIT_HI: out_s = 1'b0;
         S_HIGH:    out_s = 1'b1;
         S_WAIT_LO: out_s = 1'b1;
         default:   out_s = 1'b0;
      endcase
   end

   assign key_out = key_out_r;

`ifdef KEY_EDGE_PULSE_EN
   logic rise_r;
   logic fall_r;

   // Edge pulses land in the same cycle the debounced level changes
   always_ff @(posedge CLK) begin
      if (RST) begin
         rise_r <= 1'b0;
         fall_r <= 1'b0;
      end else begin
         rise_r <= out_s & ~key_out_r;
         fall_r <= ~out_s & key_out_r;
      end
   end

   assign key_rise = rise_r;
   assign key_fall = fall_r;
`endif

endmodule

// File: rtl/key_debounce.sv
// Debounced key front end: one independent channel per key bit.
// Defining KEY_EDGE_PULSE_EN adds the Key_Rise/Key_Fall pulse ports.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int N_KEYS          = 2,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [N_KEYS-1:0] Key_In,
   output logic [N_KEYS-1:0] Key_Out
`ifdef KEY_EDGE_PULSE_EN
   ,
   output logic [N_KEYS-1:0] Key_Rise,
   output logic [N_KEYS-1:0] Key_Fall
`endif
);

   for (genvar g = 0; g < N_KEYS; g++) begin : g_chan
      key_debounce_chan #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_chan (
         .CLK     (CLK),
         .RST     (RST),
         .key_raw (Key_In[g]),
         .key_out (Key_Out[g])
`ifdef KEY_EDGE_PULSE_EN
         ,
         .key_rise(Key_Rise[g]),
         .key_fall(Key_Fall[g])
`endif
      );
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed scoreboard bench for key_debounce (N_KEYS=2, DEBOUNCE_CYCLES=8).
// Expected level changes are queued with their due cycle when stimulus is driven.
module tb_key_debounce;
   import key_debounce_pkg::*;

   localparam int LAT = 2 + DEBOUNCE_CYCLES_SIM;

   typedef struct {
      int   when;
      int   idx;
      logic val;
      logic pulse;
   } ev_t;

   logic       CLK;
   logic       RST;
   logic [1:0] key_in;
   logic [1:0] key_out;
`ifdef KEY_EDGE_PULSE_EN
   logic [1:0] key_rise;
   logic [1:0] key_fall;
`endif

   ev_t        sb[$];
   logic [1:0] exp_out;
   int         cyc;
   int         total;
   int         bad;

   key_debounce #(
      .N_KEYS(2),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES_SIM)
   ) dut (
      .CLK     (CLK),
      .RST     (RST),
      .Key_In  (key_in),
      .Key_Out (key_out)
`ifdef KEY_EDGE_PULSE_EN
      ,
      .Key_Rise(key_rise),
      .Key_Fall(key_fall)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic push_ev(input int idx, input logic val, input logic pulse, input int when);
      ev_t e;
      e.when  = when;
      e.idx   = idx;
      e.val   = val;
      e.pulse = pulse;
      sb.push_back(e);
   endtask

   task automatic drop_pending(input int idx);
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].idx == idx) sb.delete(i);
      end
   endtask

   // Drive a clean new level; it is sampled on the next edge and due LAT edges after that
   task automatic set_key(input int idx, input logic val);
      key_in[idx] = val;
      push_ev(idx, val, 1'b1, cyc + 1 + LAT);
   endtask

   task automatic tick();
      logic [1:0] rise_e;
      logic [1:0] fall_e;
      @(posedge CLK);
      cyc++;
      @(negedge CLK);
      rise_e = 2'b00;
      fall_e = 2'b00;
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].when == cyc) begin
            if (sb[i].pulse && sb[i].val && !exp_out[sb[i].idx]) rise_e[sb[i].idx] = 1'b1;
            if (sb[i].pulse && !sb[i].val && exp_out[sb[i].idx]) fall_e[sb[i].idx] = 1'b1;
            exp_out[sb[i].idx] = sb[i].val;
            sb.delete(i);
         end
      end
      total++;
      assert (key_out === exp_out) else begin
         bad++;
         $error("FAIL key_out cyc=%0d observed=%b expected=%b", cyc, key_out, exp_out);
      end
`ifdef KEY_EDGE_PULSE_EN
      total++;
      assert (key_rise === rise_e) else begin
         bad++;
         $error("FAIL key_rise cyc=%0d observed=%b expected=%b", cyc, key_rise, rise_e);
      end
      total++;
      assert (key_fall === fall_e) else begin
         bad++;
         $error("FAIL key_fall cyc=%0d observed=%b expected=%b", cyc, key_fall, fall_e);
      end
`else
      if (rise_e != fall_e) begin
         rise_e = 2'b00;
      end
`endif
   endtask

   initial begin
      cyc     = 0;
      total   = 0;
      bad     = 0;
      exp_out = 2'b00;
      RST     = 1'b1;
      key_in  = 2'b11;

      // 1: keys held through reset report only after the full latency
      repeat (3) tick();
      RST = 1'b0;
      push_ev(0, 1'b1, 1'b1, cyc + 1 + LAT);
      push_ev(1, 1'b1, 1'b1, cyc + 1 + LAT);
      repeat (LAT + 4) tick();

      // 2: clean release of both, then a clean press on key 0
      set_key(0, 1'b0);
      set_key(1, 1'b0);
      repeat (LAT + 4) tick();
      set_key(0, 1'b1);
      repeat (LAT + 4) tick();

      // 3: 5-cycle glitch on key 1 must be rejected
      key_in[1] = 1'b1;
      repeat (5) tick();
      key_in[1] = 1'b0;
      repeat (LAT + 4) tick();

      // 4: bounce 1,0,1,0 then steady 1 on key 0
      set_key(0, 1'b0);
      repeat (LAT + 4) tick();
      key_in[0] = 1'b1;
      tick();
      key_in[0] = 1'b0;
      tick();
      key_in[0] = 1'b1;
      tick();
      key_in[0] = 1'b0;
      tick();
      set_key(0, 1'b1);
      repeat (LAT + 4) tick();

      // 5: simultaneous change, then one bounce on key 1 restarts its window
      set_key(0, 1'b0);
      set_key(1, 1'b1);
      repeat (3) tick();
      drop_pending(1);
      key_in[1] = 1'b0;
      tick();
      set_key(1, 1'b1);
      repeat (LAT + 4) tick();

      // 6: reset in the middle of a release wait, no fall pulse
      set_key(0, 1'b1);
      repeat (LAT + 4) tick();
      set_key(0, 1'b0);
      set_key(1, 1'b0);
      repeat (5) tick();
      drop_pending(0);
      drop_pending(1);
      RST = 1'b1;
      push_ev(0, 1'b0, 1'b0, cyc + 1);
      push_ev(1, 1'b0, 1'b0, cyc + 1);
      tick();
      RST = 1'b0;
      repeat (LAT + 4) tick();

      total++;
      assert (sb.size() === 0) else begin
         bad++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
